spectrum_fb_writer: RTL and testbench

- Frame-buffer writer: the producer end of the dual-page SRAM frame buffer that the LCD controller scans out.
- Accepts one bar height per column per channel from the spectrum analyser and renders a 128-pixel bar column into the back page.
- Requests SRAM write cycles through a req/ack handshake.
- Flips the displayed page on the LCD NewFrame pulse once the back page is complete.

---
 rtl/fb_pkg.sv | 46 ++++
 rtl/spectrum_fb_writer_if.sv | 26 ++
 rtl/bar_pixel_gen.sv | 27 ++
 rtl/spectrum_fb_writer.sv | 127 ++++++++++++
 tb/tb_spectrum_fb_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer package shared by the writer, the LCD scan-out side and the
// SRAM controller: address layout, geometry, pixel format and colours.
package fb_pkg;

    localparam int FB_W     = 512;
    localparam int FB_H     = 128;

    localparam int ADDR_W   = 18;
    localparam int PAGE_BIT = 17;
    localparam int LR_BIT   = 16;
    localparam int Y_MSB    = 15;
    localparam int Y_LSB    = 9;
    localparam int X_MSB    = 8;
    localparam int X_LSB    = 0;
    localparam int Y_W      = Y_MSB - Y_LSB + 1;
    localparam int X_W      = X_MSB - X_LSB + 1;

    localparam int RGB_W    = 15;
    localparam int CNT_W    = 11;

    typedef logic [RGB_W-1:0]  rgb555_t;
    typedef logic [ADDR_W-1:0] fbAddr_t;

    localparam rgb555_t DEF_BAR_COLOR = 15'h03E0;
    localparam rgb555_t DEF_CAP_COLOR = 15'h7C00;
    localparam rgb555_t DEF_BG_COLOR  = 15'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } writerState_t;

    // Pack page, channel, row and column into an SRAM word address.
    function automatic fbAddr_t makeFbAddr(input logic page, input logic lr,
                                           input logic [Y_W-1:0] y,
                                           input logic [X_W-1:0] x);
        fbAddr_t a;
        a               = '0;
        a[PAGE_BIT]     = page;
        a[LR_BIT]       = lr;
        a[Y_MSB:Y_LSB]  = y;
        a[X_MSB:X_LSB]  = x;
        return a;
    endfunction

endpackage

// File: rtl/spectrum_fb_writer_if.sv
// Bin input stream plus SRAM write request bus of the frame-buffer writer.
// The master side is the writer; the slave side is the analyser/SRAM world.
interface spectrum_fb_writer_if;
    import fb_pkg::*;

    logic             BinValid;
    logic             BinReady;
    logic             BinChannel;
    logic [X_W-1:0]   BinIndex;
    logic [Y_W-1:0]   BinHeight;

    logic             WrReq;
    logic             WrAck;
    fbAddr_t          WrAddr;
    rgb555_t          WrData;

    modport master (
        input  BinValid, BinChannel, BinIndex, BinHeight, WrAck,
        output BinReady, WrReq, WrAddr, WrData
    );

    modport slave (
        output BinValid, BinChannel, BinIndex, BinHeight, WrAck,
        input  BinReady, WrReq, WrAddr, WrData
    );
endinterface

// File: rtl/bar_pixel_gen.sv
// Colour of one pixel of a bar column: background above the bar, a cap
// pixel on the top row of the bar, bar body below it (y grows downwards).
module bar_pixel_gen import fb_pkg::*; #(
    parameter rgb555_t BAR_COLOR = DEF_BAR_COLOR,
    parameter rgb555_t CAP_COLOR = DEF_CAP_COLOR,
    parameter rgb555_t BG_COLOR  = DEF_BG_COLOR
) (
    input  logic [Y_W-1:0] y,
    input  logic [Y_W-1:0] height,
    output rgb555_t        color
);

    // 8 bits so that height 0 puts the cap row at 128, below the column.
    logic [Y_W:0] capRow;
    assign capRow = (Y_W+1)'(FB_H) - {1'b0, height};

    // Select colour by comparing the row against the cap row.
    always_comb begin
        color = BG_COLOR;
        if ({1'b0, y} == capRow) begin
            color = CAP_COLOR;
        end else if ({1'b0, y} > capRow) begin
            color = BAR_COLOR;
        end
    end

endmodule

// File: rtl/spectrum_fb_writer.sv
// Producer end of the dual-page frame buffer: renders one 128-pixel bar
// column per accepted bin into the back page and flips pages on NewFrame
// once both channels' columns are all drawn.
module spectrum_fb_writer import fb_pkg::*; #(
    parameter int      NUM_COLS  = FB_W,
    parameter rgb555_t BAR_COLOR = DEF_BAR_COLOR,
    parameter rgb555_t CAP_COLOR = DEF_CAP_COLOR,
    parameter rgb555_t BG_COLOR  = DEF_BG_COLOR
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 NewFrame,
    spectrum_fb_writer_if.master bus,
    output logic                 DispPage,
    output logic                 FrameReady,
    output logic [7:0]           SkipCount
);

    localparam logic [CNT_W-1:0] NUM_COLS_C = CNT_W'(NUM_COLS);
    localparam logic [CNT_W-1:0] FRAME_COLS = CNT_W'(2 * NUM_COLS);
    localparam logic [Y_W-1:0]   LAST_Y     = Y_W'(FB_H - 1);

    writerState_t     state;
    logic             chReg;
    logic [X_W-1:0]   xReg;
    logic [Y_W-1:0]   hReg;
    logic [Y_W-1:0]   yCnt;
    logic [CNT_W-1:0] colCount;

    logic [Y_W-1:0]   genY;
    logic [Y_W-1:0]   genH;
    rgb555_t          genColor;
    logic             binTake;
    logic             binIndexOk;

    assign binTake    = bus.BinValid & bus.BinReady;
    assign binIndexOk = {2'b00, bus.BinIndex} < NUM_COLS_C;

    // Pixel generator looks one pixel ahead: row 0 of the offered bin while
    // idle, the next row of the latched column while drawing.
    always_comb begin
        genY = '0;
        genH = bus.BinHeight;
        if (state == DRAW) begin
            genY = yCnt + Y_W'(1);
            genH = hReg;
        end
    end

    bar_pixel_gen #(
        .BAR_COLOR (BAR_COLOR),
        .CAP_COLOR (CAP_COLOR),
        .BG_COLOR  (BG_COLOR)
    ) u_pixelGen (
        .y      (genY),
        .height (genH),
        .color  (genColor)
    );

    // Writer FSM: bin intake, per-pixel write handshake, frame completion
    // and page flip / skip accounting.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            chReg        <= 1'b0;
            xReg         <= '0;
            hReg         <= '0;
            yCnt         <= '0;
            colCount     <= '0;
            bus.BinReady <= 1'b0;
            bus.WrReq    <= 1'b0;
            bus.WrAddr   <= '0;
            bus.WrData   <= '0;
            DispPage     <= 1'b0;
            FrameReady   <= 1'b0;
            SkipCount    <= '0;
        end else begin
            bus.BinReady <= (state == IDLE) && !FrameReady;

            // FrameReady implies IDLE, so a flip never lands mid-column.
            if (NewFrame) begin
                if (FrameReady) begin
                    DispPage   <= ~DispPage;
                    FrameReady <= 1'b0;
                    colCount   <= '0;
                end else if (SkipCount != 8'hFF) begin
                    SkipCount  <= SkipCount + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    // Out-of-range bins are consumed without drawing.
                    if (binTake && binIndexOk) begin
                        chReg        <= bus.BinChannel;
                        xReg         <= bus.BinIndex;
                        hReg         <= bus.BinHeight;
                        yCnt         <= '0;
                        bus.WrReq    <= 1'b1;
                        bus.WrAddr   <= makeFbAddr(~DispPage, bus.BinChannel,
                                                   '0, bus.BinIndex);
                        bus.WrData   <= genColor;
                        bus.BinReady <= 1'b0;
                        state        <= DRAW;
                    end
                end
                DRAW: begin
                    if (bus.WrAck) begin
                        if (yCnt != LAST_Y) begin
                            yCnt       <= genY;
                            bus.WrAddr <= makeFbAddr(~DispPage, chReg, genY, xReg);
                            bus.WrData <= genColor;
                        end else begin
                            bus.WrReq  <= 1'b0;
                            colCount   <= colCount + CNT_W'(1);
                            if (colCount + CNT_W'(1) == FRAME_COLS) begin
                                FrameReady <= 1'b1;
                            end
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectrum_fb_writer.sv
// Self-checking bench for spectrum_fb_writer, built with 8 columns per
// channel so that a whole frame (16 columns) fits a short run.
module tb_spectrum_fb_writer;

    localparam int NC = 8;
    localparam logic [14:0] BG  = 15'h0000;
    localparam logic [14:0] CAP = 15'h7C00;
    localparam logic [14:0] BAR = 15'h03E0;

    logic       Clock;
    logic       Reset;
    logic       NewFrame;
    logic       DispPage;
    logic       FrameReady;
    logic [7:0] SkipCount;

    spectrum_fb_writer_if bus();

    spectrum_fb_writer #(.NUM_COLS(NC)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .NewFrame   (NewFrame),
        .bus        (bus),
        .DispPage   (DispPage),
        .FrameReady (FrameReady),
        .SkipCount  (SkipCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int nChecks = 0;
    int nErr    = 0;

    // Reference state of the writer, kept as plain integers.
    int mDisp, mFrameReady, mSkip, mCols;

    typedef struct {
        bit ch;
        int x;
        int h;
        int expBg;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refAddr(input int page, input int ch, input int y, input int x);
        return 32'((page << 17) + (ch << 16) + (y << 9) + x);
    endfunction

    function automatic logic [31:0] refPixel(input int y, input int h);
        int top;
        top = 128 - h;
        if (y < top)  return 32'(BG);
        if (y == top) return 32'(CAP);
        return 32'(BAR);
    endfunction

    function automatic void modelNewFrame();
        if (mFrameReady != 0) begin
            mDisp       = 1 - mDisp;
            mFrameReady = 0;
            mCols       = 0;
        end else if (mSkip < 255) begin
            mSkip++;
        end
    endfunction

    function automatic void modelReset();
        mDisp = 0; mFrameReady = 0; mSkip = 0; mCols = 0;
    endfunction

    // Offer one bin and serve its 128 writes with random ack latency.
    // NewFrame is pulsed together with the ack of row nfAt (-1: never).
    task automatic drawColumn(input bit ch, input int x, input int h, input int nfAt,
                              output int bgSeen);
        int guard;
        int unstable;
        int d;
        logic [17:0] hA;
        logic [14:0] hD;
        bgSeen   = 0;
        unstable = 0;
        guard    = 0;
        while (bus.BinReady !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        check("bin_ready_wait", 32'(bus.BinReady), 32'd1);
        if (bus.BinReady !== 1'b1) return;
        bus.BinValid   = 1'b1;
        bus.BinChannel = ch;
        bus.BinIndex   = 9'(x);
        bus.BinHeight  = 7'(h);
        tick();
        bus.BinValid = 1'b0;
        for (int y = 0; y < 128; y++) begin
            guard = 0;
            while (bus.WrReq !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (bus.WrReq !== 1'b1) begin
                check("wrreq_timeout", 32'(bus.WrReq), 32'd1);
                return;
            end
            check("wr_addr", 32'(bus.WrAddr), refAddr(1 - mDisp, ch, y, x));
            check("wr_data", 32'(bus.WrData), refPixel(y, h));
            if (bus.WrData == BG) bgSeen++;
            hA = bus.WrAddr;
            hD = bus.WrData;
            d  = int'($urandom_range(0, 7));
            for (int k = 0; k < d; k++) begin
                tick();
                if (bus.WrReq !== 1'b1 || bus.WrAddr !== hA || bus.WrData !== hD) unstable++;
            end
            bus.WrAck = 1'b1;
            if (y == nfAt) NewFrame = 1'b1;
            tick();
            bus.WrAck = 1'b0;
            if (y == nfAt) begin
                NewFrame = 1'b0;
                modelNewFrame();
            end
        end
        mCols++;
        if (mCols == 2 * NC) mFrameReady = 1;
        check("hold_stable", 32'(unstable), 32'd0);
        check("wrreq_done", 32'(bus.WrReq), 32'd0);
        check("frame_ready", 32'(FrameReady), 32'(mFrameReady));
        // An ack with no request outstanding must start nothing.
        bus.WrAck = 1'b1;
        tick();
        bus.WrAck = 1'b0;
        check("spurious_ack", 32'(bus.WrReq), 32'd0);
        check("bin_ready_after", 32'(bus.BinReady), 32'(mFrameReady == 0));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        nErr++;
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $fatal(1, "watchdog");
    end

    initial begin
        int bg;
        int h;
        int invIdx[2];

        tbl[0] = '{ch: 1'b0, x: 5, h: 3,   expBg: 125};
        tbl[1] = '{ch: 1'b1, x: 2, h: 0,   expBg: 128};
        tbl[2] = '{ch: 1'b0, x: 7, h: 127, expBg: 1};
        tbl[3] = '{ch: 1'b1, x: 0, h: 64,  expBg: 64};
        tbl[4] = '{ch: 1'b0, x: 3, h: 1,   expBg: 127};

        Reset          = 1'b1;
        NewFrame       = 1'b0;
        bus.BinValid   = 1'b0;
        bus.BinChannel = 1'b0;
        bus.BinIndex   = '0;
        bus.BinHeight  = '0;
        bus.WrAck      = 1'b0;
        modelReset();

        // Reset state.
        tick();
        tick();
        check("rst_wrreq",      32'(bus.WrReq),    32'd0);
        check("rst_wraddr",     32'(bus.WrAddr),   32'd0);
        check("rst_wrdata",     32'(bus.WrData),   32'd0);
        check("rst_disppage",   32'(DispPage),     32'd0);
        check("rst_frameready", 32'(FrameReady),   32'd0);
        check("rst_skipcount",  32'(SkipCount),    32'd0);
        check("rst_binready",   32'(bus.BinReady), 32'd0);

        // BinReady rises one edge after release; the bin waiting since then
        // is taken on the following edge.
        Reset          = 1'b0;
        check("binready_at_release", 32'(bus.BinReady), 32'd0);
        bus.BinValid   = 1'b1;
        bus.BinChannel = 1'b0;
        bus.BinIndex   = 9'd5;
        bus.BinHeight  = 7'd3;
        tick();
        check("binready_rise", 32'(bus.BinReady), 32'd1);
        check("no_early_accept", 32'(bus.WrReq), 32'd0);

        // Table of columns with hand-computed background pixel counts.
        for (int i = 0; i < 5; i++) begin
            drawColumn(tbl[i].ch, tbl[i].x, tbl[i].h, -1, bg);
            check("tbl_bg_count", 32'(bg), 32'(tbl[i].expBg));
        end

        // Out-of-range bins: 600 arrives as 88 on the 9-bit bus, 8 is one
        // past the last column.
        invIdx[0] = 600 % 512;
        invIdx[1] = NC;
        for (int i = 0; i < 2; i++) begin
            bus.BinValid  = 1'b1;
            bus.BinIndex  = 9'(invIdx[i]);
            bus.BinHeight = 7'd50;
            tick();
            bus.BinValid = 1'b0;
            check("bad_idx_no_req", 32'(bus.WrReq), 32'd0);
            tick();
            check("bad_idx_no_req2", 32'(bus.WrReq), 32'd0);
            check("bad_idx_ready", 32'(bus.BinReady), 32'd1);
        end

        // NewFrame with a write pending mid-column: skip, no flip.
        drawColumn(1'b1, 6, 90, 40, bg);
        check("mid_nf_disp", 32'(DispPage), 32'(mDisp));
        check("mid_nf_skip", 32'(SkipCount), 32'(mSkip));

        // Random columns up to one short of a full frame.
        while (mCols < 2 * NC - 1) begin
            h = int'($urandom_range(0, 127));
            drawColumn(1'($urandom_range(0, 1)), int'($urandom_range(0, NC - 1)), h, -1, bg);
            check("rand_bg_count", 32'(bg), 32'(128 - h));
        end

        // Final column, NewFrame coincident with its last ack: still a skip.
        drawColumn(1'b0, 1, 20, 127, bg);
        check("coinc_disp", 32'(DispPage), 32'd0);
        check("coinc_skip", 32'(SkipCount), 32'(mSkip));
        check("full_frameready", 32'(FrameReady), 32'd1);

        // A full back page refuses new bins.
        bus.BinValid  = 1'b1;
        bus.BinIndex  = 9'd2;
        bus.BinHeight = 7'd10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_req", 32'(bus.WrReq), 32'd0);
            check("full_not_ready", 32'(bus.BinReady), 32'd0);
        end
        bus.BinValid = 1'b0;

        // Flip.
        NewFrame = 1'b1;
        tick();
        NewFrame = 1'b0;
        modelNewFrame();
        check("flip_disp", 32'(DispPage), 32'd1);
        check("flip_frameready", 32'(FrameReady), 32'd0);
        check("flip_binready_lag", 32'(bus.BinReady), 32'd0);
        tick();
        check("flip_binready", 32'(bus.BinReady), 32'd1);

        // Writes now go to page 0.
        h = int'($urandom_range(0, 127));
        drawColumn(1'b1, 4, h, -1, bg);
        check("page0_bg_count", 32'(bg), 32'(128 - h));

        // Skip counter saturation.
        for (int i = 0; i < 300; i++) begin
            NewFrame = 1'b1;
            tick();
            NewFrame = 1'b0;
            modelNewFrame();
            tick();
            if (i == 9) check("skip_count_10", 32'(SkipCount), 32'(mSkip));
        end
        check("skip_saturate", 32'(SkipCount), 32'd255);
        check("skip_no_flip", 32'(DispPage), 32'd1);

        // Asynchronous reset in the middle of a column.
        bus.BinValid   = 1'b1;
        bus.BinChannel = 1'b1;
        bus.BinIndex   = 9'd3;
        bus.BinHeight  = 7'd50;
        tick();
        bus.BinValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.WrAck = 1'b1;
            tick();
            bus.WrAck = 1'b0;
            tick();
        end
        check("pre_reset_wrreq", 32'(bus.WrReq), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_wrreq", 32'(bus.WrReq), 32'd0);
        check("async_rst_disp", 32'(DispPage), 32'd0);
        check("async_rst_skip", 32'(SkipCount), 32'd0);
        check("async_rst_addr", 32'(bus.WrAddr), 32'd0);
        tick();
        Reset = 1'b0;
        modelReset();
        tick();
        check("post_rst_ready", 32'(bus.BinReady), 32'd1);
        drawColumn(1'b0, 0, 127, -1, bg);
        check("post_rst_bg_count", 32'(bg), 32'd1);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
